// File: rtl/axi_stb_write_master_if.sv
// AXI4 write-channel bundle (AW/W/B) between the store-buffer master and the fabric.
interface axi_stb_write_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128
);
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast, bready,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast, bready,
    output awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/axi_stb_write_master.sv
// Single-outstanding AXI4 INCR write-burst master: one command -> AW, pass-through W beats, B -> done pulse.
module axi_stb_write_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic                    wr_data_valid,
  output logic                    wr_data_ready,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  axi_stb_write_master_if.master  axi,
  output logic                    done_valid,
  output logic [1:0]              done_resp,
  output logic [7:0]              err_cnt
);
  localparam int SIZE = $clog2(DATA_WIDTH/8);

  typedef enum logic [1:0] {IDLE, AW, W, B} state_t;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
  } aw_t;

  state_t     state, state_nxt;
  aw_t        aw_q;
  logic [7:0] beat_cnt;
  logic       last;

  assign last        = (beat_cnt == aw_q.len);
  assign axi.awaddr  = aw_q.addr;
  assign axi.awlen   = aw_q.len;
  assign axi.awsize  = 3'(SIZE);
  assign axi.awburst = 2'b01;
  assign axi.wdata   = wr_data;
  assign axi.wstrb   = wr_strb;

  always_comb begin
    state_nxt     = state;
    cmd_ready     = 1'b0;
    axi.awvalid   = 1'b0;
    axi.wvalid    = 1'b0;
    axi.wlast     = 1'b0;
    axi.bready    = 1'b0;
    wr_data_ready = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = AW;
      end
      AW: begin
        axi.awvalid = 1'b1;
        if (axi.awready) state_nxt = W;
      end
      W: begin
        // W is a straight wire to the store-data stream; only wlast is generated here
        axi.wvalid    = wr_data_valid;
        wr_data_ready = axi.wready;
        axi.wlast     = last;
        if (wr_data_valid && axi.wready && last) state_nxt = B;
      end
      B: begin
        axi.bready = 1'b1;
        if (axi.bvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      aw_q       <= '0;
      beat_cnt   <= '0;
      err_cnt    <= '0;
      done_valid <= 1'b0;
      done_resp  <= 2'b00;
    end else begin
      state      <= state_nxt;
      done_valid <= 1'b0;
      if (state == IDLE && cmd_valid) begin
        aw_q.addr <= {cmd_addr[ADDR_WIDTH-1:SIZE], {SIZE{1'b0}}};
        aw_q.len  <= 8'(cmd_len);
      end
      if (state == AW && axi.awready) beat_cnt <= '0;
      if (state == W && wr_data_valid && axi.wready) beat_cnt <= beat_cnt + 8'd1;
      if (state == B && axi.bvalid) begin
        done_valid <= 1'b1;
        done_resp  <= axi.bresp;
        if (axi.bresp != 2'b00 && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end
endmodule

// File: doc/axi_stb_write_master.md
Name: axi_stb_write_master

Overview:
- AXI4 write-burst master for the store-buffer (stb) cell: accepts one store command (address + beat count), streams the matching data beats onto AW/W, collects B, and reports completion.
- Its AXI write-channel outputs are the signals the cell's AXI protocol checker monitors, so it must never trip that checker's ordering or BRESP rules.
- One outstanding transaction; AW always handshakes before any W beat is presented.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 128, AXI data width (power of two, 32..1024).
- LEN_WIDTH, 4, command beat-count field width (max burst = 2^LEN_WIDTH beats).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  store command valid.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_addr  in  ADDR_WIDTH  burst start byte address.
- cmd_len  in  LEN_WIDTH  beats minus one.
- wr_data_valid  in  1  store data beat valid.
- wr_data_ready  out  1  store data beat consumed.
- wr_data  in  DATA_WIDTH  beat data.
- wr_strb  in  DATA_WIDTH/8  beat byte strobes.
- axi_awvalid  out  1.
- axi_awready  in  1.
- axi_awaddr  out  ADDR_WIDTH.
- axi_awlen  out  8.
- axi_awsize  out  3.
- axi_awburst  out  2.
- axi_wvalid  out  1.
- axi_wready  in  1.
- axi_wdata  out  DATA_WIDTH.
- axi_wstrb  out  DATA_WIDTH/8.
- axi_wlast  out  1.
- axi_bvalid  in  1.
- axi_bready  out  1.
- axi_bresp  in  2.
- done_valid  out  1  one-cycle completion pulse.
- done_resp  out  2  BRESP of the completed burst.
- err_cnt  out  8  saturating count of non-OKAY responses.

Behaviour:
- FSM states: IDLE, AW, W, B. Reset takes effect at the next clk edge while rst=1, from any state, including mid-burst. Reset sends the FSM to IDLE and clears beat_cnt, err_cnt, done_valid, done_resp and all AXI valid/ready outputs to 0. The AW registers reset to 0.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, register: awaddr = cmd_addr with low log2(DATA_WIDTH/8) bits cleared; awlen = zero-extended cmd_len.
  - Transition to AW on the next cycle; axi_awvalid rises 1 cycle after acceptance.
- AW:
  - axi_awvalid=1; awaddr/awlen held stable until axi_awready=1.
  - axi_awsize = log2(DATA_WIDTH/8) (4 for 128); axi_awburst = 2'b01 (INCR), constant.
  - On handshake go to W; beat_cnt=0.
  - axi_wvalid stays 0 throughout AW, even if axi_wready or wr_data_valid is high.
- W:
  - Data path is pass-through: axi_wvalid = wr_data_valid; wr_data_ready = axi_wready; axi_wdata = wr_data; axi_wstrb = wr_strb.
  - axi_wlast = (beat_cnt == awlen).
  - beat_cnt increments on each wvalid && wready.
  - On the handshake with wlast=1, go to B.
  - Outside W: wr_data_ready=0, axi_wvalid=0, axi_wlast=0.
- B:
  - axi_bready=1.
  - On axi_bvalid: done_valid=1 for exactly the next cycle, done_resp=axi_bresp registered; return to IDLE.
  - If axi_bresp != 2'b00, err_cnt increments, saturating at 255.
  - A new command is accepted no earlier than the cycle after done_valid (IDLE).
- cmd_ready=0 in AW/W/B; commands are never dropped, they wait.
- Single-beat burst (cmd_len=0): wlast=1 on the first beat.
- Command contract: callers guarantee that a burst does not cross a 4 KB boundary. The block does not split bursts.
- Any bvalid outside state B is ignored (bready=0).
- No internal timeout; hang detection belongs to the protocol checker.

Test Plan:
- cmd_addr=0x1000_0013, cmd_len=3, awready/wready/bvalid always 1:
  - axi_awaddr=0x1000_0010, awlen=3, awsize=4, awburst=1.
  - 4 W beats on consecutive cycles, wlast only on beat 4.
  - done_valid pulses with done_resp=0; err_cnt=0.
- awready held 0 for 20 cycles with wr_data_valid=1 and wready=1:
  - awvalid/awaddr stable for all 20 cycles.
  - axi_wvalid=0 and wr_data_ready=0 until the AW handshake.
- cmd_len=0 with wready toggling 0/1:
  - Exactly one W handshake, with wlast=1 and wdata/wstrb equal to the input beat.
  - bready rises only after that handshake.
- Two bursts, the first with bresp=2'b10:
  - done_resp=2 then 0; err_cnt=1.
  - A second cmd_valid held high during the first burst is accepted only in IDLE.
- rst=1 for 1 cycle during beat 2 of a 4-beat burst:
  - Next cycle: all AXI valids=0, cmd_ready=1, beat_cnt=0.
  - A following cmd_len=1 burst completes normally with 2 beats.
- 300 back-to-back bursts, all bresp=2'b11:
  - err_cnt saturates at 255.
  - No protocol-checker error code 6 or 7 is ever raised.
